// File: rtl/core_mem_arbiter.sv
// Shares one memory bus between fetch and load/store; ready->rvalid is 3 cycles minimum.
// One transaction in flight; requesters hold until ready, the bus holds us via mem_gnt.
module core_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_kill,
    output logic                i_ready,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic       owner_d;
    logic       kill_pend;
    logic [3:0] starve_cnt;
    logic       idle;
    logic       i_win;

    // Ready is gated with rst_n so every output reads 0 while reset is held.
    assign idle    = (state == IDLE) && rst_n;
    assign i_win   = i_req && (!d_req || (starve_cnt == STARVE_LIM));
    assign i_ready = idle && i_win;
    assign d_ready = idle && d_req && !i_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            kill_pend  <= 1'b0;
            starve_cnt <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            if (d_ready && i_req) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (i_ready || !i_req) begin
                starve_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (d_ready) begin
                        owner_d   <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_wen   <= d_wen;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_wstrb;
                        state     <= REQ;
                    end else if (i_ready) begin
                        owner_d   <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_wen   <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        kill_pend <= i_kill;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (i_kill && !owner_d) begin
                        kill_pend <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state     <= IDLE;
                        kill_pend <= 1'b0;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_wen ? '0 : mem_rdata;
                        end else if (!kill_pend && !i_kill) begin
                            // A kill landing on the completion cycle still discards it.
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end else if (i_kill && !owner_d) begin
                        kill_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: bus model plus response scoreboard.
module tb_core_mem_arbiter;
    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_kill = 1'b0;
    logic        i_ready, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ready, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic [137:0] all_out;
    assign all_out = {i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
                      mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb};

    int checks = 0;
    int errors = 0;
    int gnt_delay = 0;
    int rsp_delay = 0;
    exp_t sb[$];
    logic [31:0] mem_data [logic [31:0]];

    core_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bus_data(input logic [31:0] a);
        return mem_data.exists(a) ? mem_data[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // Bus model: grant after gnt_delay cycles of mem_req, respond rsp_delay+1 cycles later.
    initial begin : bus_model
        int gcnt;
        int pend;
        logic [31:0] rsp;
        gcnt = 0;
        pend = 0;
        rsp  = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                gcnt = 0;
                pend = 0;
            end else if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rsp;
                end
            end else if (mem_req) begin
                if (gcnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    gcnt    = 0;
                    pend    = rsp_delay + 1;
                    rsp     = mem_wen ? 32'h0 : bus_data(mem_addr);
                end else begin
                    gcnt++;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && d_rvalid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL d_resp: unexpected d_rvalid with data %h, required no response", d_rdata);
                end else begin
                    e = sb.pop_front();
                    if (e.is_d !== 1'b1 || d_rdata !== e.data) begin
                        errors++;
                        $display("FAIL d_resp: got D response %h, required owner_d=%0d data %h", d_rdata, e.is_d, e.data);
                    end
                end
            end
            if (rst_n && i_rvalid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL i_resp: unexpected i_rvalid with data %h, required no response", i_rdata);
                end else begin
                    e = sb.pop_front();
                    if (e.is_d !== 1'b0 || i_rdata !== e.data) begin
                        errors++;
                        $display("FAIL i_resp: got I response %h, required owner_d=%0d data %h", i_rdata, e.is_d, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic drain(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs %h, required 0", all_out);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs %h, required 0", all_out);
        end
    endtask

    task automatic test_single_load;
        mem_data[32'h100] = 32'hDEADBEEF;
        @(posedge clk); #1;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h100; d_wdata = '0; d_wstrb = '0;
        sb.push_back({1'b1, 32'hDEADBEEF});
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_t0_ready: d_ready=%b i_ready=%b, required 1 0", d_ready, i_ready);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL load_t1_bus: req=%b wen=%b addr=%h, required 1 0 00000100", mem_req, mem_wen, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_t2_req_drop: mem_req=%b, required 0", mem_req);
        end
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL load_t3_resp: d_rvalid=%b d_rdata=%h i_rvalid=%b, required 1 deadbeef 0", d_rvalid, d_rdata, i_rvalid);
        end
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL load_t4_pulse: d_rvalid=%b, required 0", d_rvalid);
        end
        drain(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL load_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_store_wait;
        int pulses;
        gnt_delay = 2;
        @(posedge clk); #1;
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'h3;
        sb.push_back({1'b1, 32'h0});
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_ready: d_ready=%b, required 1", d_ready);
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_wen = 1'b0; d_addr = 32'hFFFF; d_wdata = '0; d_wstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 32'h200 ||
                mem_wdata !== 32'h12345678 || mem_wstrb !== 4'h3) begin
                errors++;
                $display("FAIL store_hold%0d: req=%b wen=%b addr=%h wdata=%h wstrb=%h, required 1 1 00000200 12345678 3",
                         k, mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb);
            end
        end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_rvalid) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL store_ack_pulses: got %0d, required 1", pulses);
        end
        gnt_delay = 0;
        drain(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL store_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_starvation;
        logic [9:0] exp_order;
        int n;
        bit both;
        exp_order = 10'b1111011110;
        n = 0;
        both = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h2000;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge clk);
            if (i_ready && d_ready) both = 1'b1;
            if (i_ready || d_ready) begin
                checks++;
                if (d_ready !== exp_order[9-n]) begin
                    errors++;
                    $display("FAIL starve_grant%0d: d_ready=%b, required %b", n, d_ready, exp_order[9-n]);
                end
                if (d_ready) sb.push_back({1'b1, bus_data(32'h2000)});
                else         sb.push_back({1'b0, bus_data(32'h1000)});
                n++;
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL starve_count: got %0d grants, required 10", n);
        end
        checks++;
        if (both) begin
            errors++;
            $display("FAIL starve_exclusive: both readies seen high, required never");
        end
        drain(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL starve_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_kill;
        bit seen;
        bit got;
        logic [31:0] rd;
        mem_data[32'h40] = 32'hAAAA5555;
        for (int mode = 0; mode < 2; mode++) begin
            rsp_delay = 2;
            @(posedge clk); #1;
            i_req = 1'b1; i_addr = 32'h40;
            i_kill = (mode == 1);
            @(negedge clk);
            checks++;
            if (i_ready !== 1'b1) begin
                errors++;
                $display("FAIL kill%0d_ready: i_ready=%b, required 1", mode, i_ready);
            end
            @(posedge clk); #1;
            i_req = 1'b0; i_kill = 1'b0;
            if (mode == 0) begin
                @(posedge clk); #1;
                i_kill = 1'b1;
                @(posedge clk); #1;
                i_kill = 1'b0;
            end
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (i_rvalid) seen = 1'b1;
            end
            checks++;
            if (seen) begin
                errors++;
                $display("FAIL kill%0d_suppress: i_rvalid seen, required none", mode);
            end
            rsp_delay = 0;
            @(posedge clk); #1;
            i_req = 1'b1; i_addr = 32'h80;
            sb.push_back({1'b0, bus_data(32'h80)});
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (i_ready) got = 1'b1;
            end
            @(posedge clk); #1;
            i_req = 1'b0;
            got = 1'b0;
            rd = '0;
            for (int c = 0; c < 12 && !got; c++) begin
                @(negedge clk);
                if (i_rvalid) begin
                    got = 1'b1;
                    rd = i_rdata;
                end
            end
            checks++;
            if (!got || rd !== bus_data(32'h80)) begin
                errors++;
                $display("FAIL kill%0d_next_fetch: seen=%b data=%h, required 1 %h", mode, got, rd, bus_data(32'h80));
            end
            drain(10);
        end
    endtask

    task automatic test_reset_mid;
        gnt_delay = 5;
        @(posedge clk); #1;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h300;
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: d_ready=%b, required 1", d_ready);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_req: mem_req=%b, required 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rstmid_async: outputs %h, required 0", all_out);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        gnt_delay = 0;
        @(posedge clk); #1;
        d_req = 1'b1; d_addr = 32'h304;
        sb.push_back({1'b1, bus_data(32'h304)});
        @(negedge clk);
        checks++;
        if (d_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_first_accept: d_ready=%b, required 1", d_ready);
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        drain(10);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rstmid_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        bit got1;
        bit got2;
        sb.push_back({1'b1, bus_data(32'h400)});
        sb.push_back({1'b1, bus_data(32'h404)});
        @(posedge clk); #1;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h400;
        got1 = 1'b0;
        for (int c = 0; c < 10 && !got1; c++) begin
            @(negedge clk);
            if (d_ready) got1 = 1'b1;
        end
        @(posedge clk); #1;
        d_addr = 32'h404;
        got2 = 1'b0;
        for (int c = 0; c < 10 && !got2; c++) begin
            @(negedge clk);
            if (d_ready) begin
                got2 = 1'b1;
                checks++;
                if (d_rvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_overlap: d_rvalid=%b at second d_ready, required 1", d_rvalid);
                end
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        checks++;
        if (!got1 || !got2) begin
            errors++;
            $display("FAIL b2b_accepts: first=%b second=%b, required 1 1", got1, got2);
        end
        drain(12);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_wait();
        test_starvation();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one single-ported memory bus between the fetch stage (I-side) and the memory stage's load/store unit (D-side).
- Arbitrates between the two sides, sequences one outstanding bus transaction at a time and routes the response back to its owner.
- Supports fetch kill on redirect and bounds fetch starvation.
- Sits between the core pipeline and the unified memory/bus adapter; the pipeline stalls on the ready/rvalid signals defined here.

Parameters:
- ADDR_W, 32, address width of all three ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- STARVE_MAX, 4, consecutive D-side grants allowed while i_req is pending before fetch is forced to win; range 1..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ready
- i_addr  in  ADDR_W  fetch address
- i_kill  in  1  discard the in-flight or just-accepted fetch response (redirect/flush)
- i_ready  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid, one-cycle pulse
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  load/store request; held with its fields until d_ready
- d_wen  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  byte strobes
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data or store acknowledge, one-cycle pulse
- d_rdata  out  DATA_W  load data
- mem_req  out  1  bus request; held until mem_gnt
- mem_wen  out  1  bus write
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_wstrb  out  DATA_W/8  bus strobes
- mem_gnt  in  1  bus accepted request
- mem_rvalid  in  1  bus response (read data or write ack)
- mem_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (async assert, sync deassert in clk domain):
  - state=IDLE; owner=I; kill_pend=0; starve_cnt=0.
  - All outputs 0, including i_rdata/d_rdata and all mem_* fields.
- States:
  - IDLE: arbitrate.
  - REQ: mem_req=1, waiting for mem_gnt.
  - WAIT: waiting for mem_rvalid.
- IDLE arbitration (combinational ready, accept at clock edge):
  - Only d_req: d_ready=1.
  - Only i_req: i_ready=1.
  - Both: D wins unless starve_cnt==STARVE_MAX, then I wins.
  - Neither: stay in IDLE.
  - i_ready/d_ready are never 1 outside IDLE and never both 1.
- On accept:
  - Latch owner and request fields into the mem_* registers; next state=REQ.
  - mem_req rises the cycle after ready.
  - Fetch accept sets mem_wen=0 and mem_wstrb=0.
- REQ: mem_* held stable; on mem_gnt, next state=WAIT and mem_req drops next cycle.
- WAIT:
  - On mem_rvalid, next state=IDLE.
  - The owner's rvalid pulses the following cycle with rdata registered from mem_rdata.
  - Store ack drives d_rvalid=1 with d_rdata=0.
  - A new request may be accepted in that same cycle, since state is IDLE.
- Timing:
  - Minimum request-to-response is 3 cycles: ready at T, mem_req at T+1 with gnt, mem_rvalid at T+2, rvalid at T+3.
  - Sustained throughput is one transaction per 3 cycles.
- mem_rvalid is ignored outside WAIT. The memory must not respond in the grant cycle.
- Starvation counter:
  - On a D grant while i_req=1: starve_cnt+=1, saturating at STARVE_MAX.
  - On an I grant, or any cycle with i_req=0: starve_cnt=0.
- Kill:
  - i_kill while owner=I in REQ or WAIT sets kill_pend.
  - i_kill in the same cycle as i_ready also sets kill_pend.
  - The bus transaction completes normally, but i_rvalid stays 0 for it and kill_pend clears when it completes.
  - i_kill with no fetch in flight has no effect.
  - i_kill never affects D-side transactions.
- Reset mid-operation: the state and any in-flight transaction are dropped immediately. The bus is reset by the same rst_n.

Test Plan:
- Single load: d_req=1, d_addr=0x100, mem_gnt=1 on first mem_req, mem_rvalid=1 with mem_rdata=0xDEADBEEF the next cycle.
  - Required: d_ready at T0, mem_req at T1, d_rvalid=1 with d_rdata=0xDEADBEEF at T3, and i_rvalid stays 0.
- Store with wait states: d_wen=1, d_addr=0x200, d_wdata=0x12345678, d_wstrb=0x3, mem_gnt delayed 2 cycles.
  - Required: mem_req held 3 cycles with stable fields, mem_wstrb=0x3, then one d_rvalid pulse.
- Contention/starvation with STARVE_MAX=4, i_req and d_req held high with immediate gnt/rvalid.
  - Required grant order D,D,D,D,I,D,D,D,D,I; i_ready and d_ready are never both 1.
- Kill: fetch accepted at 0x40, i_kill pulsed while in WAIT, mem_rvalid=1 with 0xAAAA5555.
  - Required: i_rvalid stays 0 and the next fetch to 0x80 returns normally.
  - Repeat with i_kill coincident with i_ready; the same response is required.
- Reset mid-operation: assert rst_n=0 while in REQ with mem_req=1.
  - Required: mem_req=0 and all outputs 0 asynchronously, before the next clk edge.
  - After release, the first d_req is accepted immediately in IDLE.
- Back-to-back: d_req held for two loads.
  - Required: the second d_ready coincides with the first d_rvalid cycle.
